// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: owns the single port of the synchronous map ROM and shares it between the
// scanline renderer (one tile-row fetch per line) and game-logic wall queries.
// Render fetches always win over queries, but a query that is already in flight runs to
// completion first. The renderer fills a shadow row that is swapped into row_bits at the end of
// each line.

module map_rom_arbiter #(
  parameter int unsigned MAP_W    = 30,
  parameter int unsigned MAP_H    = 21,
  parameter int unsigned TILE     = 20,
  parameter int unsigned ROW_W    = 5,
  parameter int unsigned COL_W    = 5,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_MAX    = 799,
  parameter int unsigned V_MAX    = 599
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [9:0]       i_h_counter,
  input  logic [9:0]       i_v_counter,
  output logic [ROW_W-1:0] o_rom_addr,
  input  logic [MAP_W-1:0] i_rom_data,
  input  logic             i_q_req,
  input  logic [ROW_W-1:0] i_q_row,
  input  logic [COL_W-1:0] i_q_col,
  output logic             o_q_ack,
  output logic             o_q_hit,
  output logic [MAP_W-1:0] o_row_bits,
  output logic             o_row_valid,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StRIssue,
    StRWait,
    StQIssue,
    StQWait,
    StQDone
  } state_e;

  state_e           r_state;
  logic [ROW_W-1:0] r_rom_addr;
  logic             r_q_ack;
  logic             r_q_hit;
  logic [COL_W-1:0] r_q_col;
  logic [MAP_W-1:0] r_shadow;
  logic             r_shadow_valid;
  logic [MAP_W-1:0] r_row_bits;
  logic             r_row_valid;
  logic             r_render_pending;
  logic [ROW_W-1:0] r_nrow;
  logic             r_nvalid;

  logic             w_trigger;
  logic             w_swap;
  logic [9:0]       w_nv;
  logic [31:0]      w_nrow_full;
  logic [ROW_W-1:0] w_nrow;
  logic             w_nvalid;
  logic             w_pend;
  logic [ROW_W-1:0] w_pend_row;
  logic             w_pend_valid;
  logic             w_q_oob;

  assign w_trigger   = (32'(i_h_counter) == H_ACTIVE);
  assign w_swap      = (32'(i_h_counter) == H_MAX);
  // Row needed by the next line; the last line of the frame wraps to line 0.
  assign w_nv        = (32'(i_v_counter) == V_MAX) ? 10'd0 : i_v_counter + 10'd1;
  assign w_nrow_full = 32'(w_nv) / TILE;
  assign w_nrow      = w_nrow_full[ROW_W-1:0];
  assign w_nvalid    = (w_nrow_full < MAP_H);

  // A trigger in the current cycle counts as pending so render beats a same-cycle query.
  assign w_pend       = r_render_pending | w_trigger;
  assign w_pend_row   = w_trigger ? w_nrow : r_nrow;
  assign w_pend_valid = w_trigger ? w_nvalid : r_nvalid;

  // Out-of-range tiles read as wall without touching the ROM.
  assign w_q_oob = (32'(i_q_row) >= MAP_H) || (32'(i_q_col) >= MAP_W);

  // Remember a render request that arrives while the FSM is busy with a query.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_render_pending <= 1'b0;
      r_nrow           <= '0;
      r_nvalid         <= 1'b0;
    end else if (r_state == StIdle && w_pend) begin
      r_render_pending <= 1'b0;
    end else if (w_trigger) begin
      r_render_pending <= 1'b1;
      r_nrow           <= w_nrow;
      r_nvalid         <= w_nvalid;
    end
  end

  // Arbitration FSM: owns the ROM address, the shadow row and the query response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_rom_addr     <= '0;
      r_q_ack        <= 1'b0;
      r_q_hit        <= 1'b0;
      r_q_col        <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
    end else begin
      r_q_ack <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_pend) begin
            if (w_pend_valid) begin
              r_rom_addr <= w_pend_row;
              r_state    <= StRIssue;
            end else begin
              r_shadow       <= '0;
              r_shadow_valid <= 1'b0;
            end
          end else if (i_q_req) begin
            r_q_col <= i_q_col;
            if (w_q_oob) begin
              r_q_hit <= 1'b1;
              r_q_ack <= 1'b1;
              r_state <= StQDone;
            end else begin
              r_rom_addr <= i_q_row;
              r_state    <= StQIssue;
            end
          end
        end
        StRIssue: r_state <= StRWait;
        StRWait: begin
          r_shadow       <= i_rom_data;
          r_shadow_valid <= 1'b1;
          r_state        <= StIdle;
        end
        StQIssue: r_state <= StQWait;
        StQWait: begin
          // Ack is registered here so it is high exactly during StQDone.
          r_q_hit <= i_rom_data[r_q_col];
          r_q_ack <= 1'b1;
          r_state <= StQDone;
        end
        StQDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // End-of-line swap: the fetched row becomes visible from h_counter==0 of the next line.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row_bits  <= '0;
      r_row_valid <= 1'b0;
    end else if (w_swap) begin
      r_row_bits  <= r_shadow;
      r_row_valid <= r_shadow_valid;
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_q_ack     = r_q_ack;
  assign o_q_hit     = r_q_hit;
  assign o_row_bits  = r_row_bits;
  assign o_row_valid = r_row_valid;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Testbench for map_rom_arbiter: behavioural ROM, directed stimulus, query scoreboard.

module tb_map_rom_arbiter;

  localparam int unsigned MAP_W = 30;
  localparam int unsigned MAP_H = 21;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned COL_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [9:0]       h_counter;
  logic [9:0]       v_counter;
  logic [ROW_W-1:0] rom_addr;
  logic [MAP_W-1:0] rom_data;
  logic             q_req;
  logic [ROW_W-1:0] q_row;
  logic [COL_W-1:0] q_col;
  logic             q_ack;
  logic             q_hit;
  logic [MAP_W-1:0] row_bits;
  logic             row_valid;
  logic             busy;

  logic [MAP_W-1:0] mem [0:31];
  logic [MAP_W-1:0] cur_bits;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   cyc;
    logic hit;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data valid the cycle after the address is presented.
  always @(posedge clk) rom_data <= mem[rom_addr];

  map_rom_arbiter #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_h_counter (h_counter),
    .i_v_counter (v_counter),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .i_q_req     (q_req),
    .i_q_row     (q_row),
    .i_q_col     (q_col),
    .o_q_ack     (q_ack),
    .o_q_hit     (q_hit),
    .o_row_bits  (row_bits),
    .o_row_valid (row_valid),
    .o_busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_oob(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return (int'(r) >= MAP_H) || (int'(c) >= MAP_W);
  endfunction

  function automatic logic exp_hit(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    logic [MAP_W-1:0] w;
    if (is_oob(r, c)) return 1'b1;
    w = mem[r];
    return w[c];
  endfunction

  task automatic push(input int lat, input logic hit);
    exp_t e;
    e.cyc = cyc + lat;
    e.hit = hit;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every ack must match the oldest expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_ack === 1'b1) begin
        n_tests++;
        assert (sb.size() != 0)
        else begin
          n_fail++;
          $error("FAIL unexpected_ack cyc=%0d got ack=1 expected no ack", cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_tests++;
          assert (cyc === e.cyc)
          else begin
            n_fail++;
            $error("FAIL ack_cycle got=%0d expected=%0d", cyc, e.cyc);
          end
          n_tests++;
          assert (q_hit === e.hit)
          else begin
            n_fail++;
            $error("FAIL ack_hit got=%0b expected=%0b", q_hit, e.hit);
          end
        end
      end
    end
  end

  // Single idle-line query with a bounded wait for the ack.
  task automatic query(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    logic             exp;
    logic [ROW_W-1:0] prev_addr;
    bit               seen;
    exp       = exp_hit(r, c);
    prev_addr = rom_addr;
    q_row     = r;
    q_col     = c;
    q_req     = 1'b1;
    push(is_oob(r, c) ? 1 : 3, exp);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (i == 0) check("q_addr", 32'(rom_addr), is_oob(r, c) ? 32'(prev_addr) : 32'(r));
      if (q_ack === 1'b1) seen = 1'b1;
    end
    check("q_ack_seen", 32'(seen), 32'd1);
    q_req = 1'b0;
    tick();
    check("q_hit_held", 32'(q_hit), 32'(exp));
  endtask

  // Drive h_counter across blanking for one line, optionally racing a query against the trigger.
  task automatic sweep_line(input int v, input bit with_q, input logic [ROW_W-1:0] r,
                            input logic [COL_W-1:0] c);
    int               nv;
    int               nrow;
    bit               exp_valid;
    logic [MAP_W-1:0] exp_row;
    logic [ROW_W-1:0] prev_addr;
    nv        = (v == 599) ? 0 : v + 1;
    nrow      = nv / 20;
    exp_valid = (nrow < 21);
    exp_row   = exp_valid ? mem[nrow] : '0;
    prev_addr = rom_addr;
    v_counter = 10'(v);
    for (int h = 640; h <= 799; h++) begin
      h_counter = 10'(h);
      if (h == 640 && with_q) begin
        q_row = r;
        q_col = c;
        q_req = 1'b1;
        push(6, exp_hit(r, c));
      end
      if (h == 641) begin
        check("render_addr", 32'(rom_addr), exp_valid ? 32'(nrow) : 32'(prev_addr));
        check("render_busy", 32'(busy), 32'(exp_valid));
      end
      if (h == 799) check("pre_swap_bits", 32'(row_bits), 32'(cur_bits));
      tick();
      if (q_ack === 1'b1) q_req = 1'b0;
    end
    q_req     = 1'b0;
    h_counter = 10'd0;
    check("row_bits", 32'(row_bits), 32'(exp_row));
    check("row_valid", 32'(row_valid), 32'(exp_valid));
    cur_bits = exp_row;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = MAP_W'(32'h9E37_79B9 * (i + 1));
    mem[0]   = 30'h2000_0001;
    mem[4]   = 30'h0123_4567;
    mem[5]   = 30'h0000_0021;
    cur_bits = '0;

    // Reset with a query pending: nothing may happen.
    reset     = 1'b1;
    h_counter = 10'd100;
    v_counter = 10'd0;
    q_req     = 1'b1;
    q_row     = 5'd5;
    q_col     = 5'd5;
    tick();
    tick();
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_q_ack", 32'(q_ack), 32'd0);
    check("rst_q_hit", 32'(q_hit), 32'd0);
    check("rst_row_bits", 32'(row_bits), 32'd0);
    check("rst_row_valid", 32'(row_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    q_req = 1'b0;
    tick();

    // Render fetch of row 5.
    sweep_line(99, 1'b0, '0, '0);

    // Idle-line queries, in range and out of range.
    query(5'd5, 5'd5);
    query(5'd5, 5'd1);
    query(5'd4, 5'd2);
    query(5'd21, 5'd0);
    query(5'd0, 5'd30);
    query(5'd31, 5'd31);

    // Query raised together with the render trigger.
    sweep_line(79, 1'b1, 5'd5, 5'd1);

    // Below the map, then frame wrap to row 0.
    sweep_line(419, 1'b0, '0, '0);
    sweep_line(599, 1'b0, '0, '0);

    // Reset while the query is in Q_WAIT: abandoned, no ack.
    q_row = 5'd5;
    q_col = 5'd5;
    q_req = 1'b1;
    tick();
    tick();
    check("qwait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    q_req = 1'b0;
    tick();
    check("mid_rst_q_ack", 32'(q_ack), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_row_bits", 32'(row_bits), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/map_rom_arbiter.md
Name: map_rom_arbiter

Overview:
- Owns the single port of the synchronous map ROM (one word per tile row, MAP_W bits per word).
- Shares that port between two requesters:
  - the scanline renderer, which needs the next line's tile-row bits at the start of every line;
  - game logic, which needs single-tile wall queries for player collision.
- Sits between the map ROM instance and the VGA pixel pipeline / player movement logic, clocked on the pixel clock.

Parameters:
MAP_W, 30, tiles per map row (ROM word width)
MAP_H, 21, tile rows in map (ROM depth)
TILE, 20, tile edge in pixels
ROW_W, 5, row index / ROM address width (clog2(MAP_H))
COL_W, 5, column index width (clog2(MAP_W))
H_ACTIVE, 640, first h_counter value of horizontal blanking
H_MAX, 799, last h_counter value of a line
V_MAX, 599, last v_counter value of a frame

Ports:
clk  in  1  pixel clock; one clock for the whole block
reset  in  1  synchronous, active-high reset
h_counter  in  10  current horizontal pixel counter
v_counter  in  10  current vertical line counter
rom_addr  out  ROW_W  ROM address, registered
rom_data  in  MAP_W  ROM word; valid the cycle after rom_addr is presented
q_req  in  1  game-logic query request, level
q_row  in  ROW_W  query tile row
q_col  in  COL_W  query tile column
q_ack  out  1  one-cycle pulse: query complete
q_hit  out  1  tile is wall; valid while q_ack=1, held afterwards
row_bits  out  MAP_W  tile bits for the current line; bit c = column c
row_valid  out  1  current line lies inside the map
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: rom_addr=0, q_ack=0, q_hit=0, row_bits=0, row_valid=0, busy=0, FSM=IDLE, render_pending=0, shadow=0, shadow_valid=0.
- Reset asserted mid-transaction: the transaction is abandoned and no q_ack is issued.
- Render trigger: when h_counter==H_ACTIVE, set render_pending.
  - nv = (v_counter==V_MAX) ? 0 : v_counter+1.
  - nrow = nv/TILE, integer division.
  - Capture nrow and nvalid = (nrow < MAP_H).
- Line swap: when h_counter==H_MAX, row_bits<=shadow and row_valid<=shadow_valid. Effective from h_counter==0 of the next line.
- FSM states are IDLE, R_ISSUE, R_WAIT, Q_ISSUE, Q_WAIT, Q_DONE.
- IDLE:
  - If render_pending: clear render_pending.
    - If nvalid: rom_addr<=nrow and go to R_ISSUE.
    - Otherwise: shadow<=0, shadow_valid<=0, stay in IDLE (no ROM access).
  - Else if q_req: latch q_row/q_col.
    - If q_row>=MAP_H or q_col>=MAP_W: go to Q_DONE with hit=1 (out of bounds is wall, no ROM access).
    - Otherwise: rom_addr<=q_row and go to Q_ISSUE.
- Render always wins a same-cycle contest with q_req. Arbitration is non-preemptive: a query in flight completes first, and the render fetch starts in the following IDLE cycle.
- R_ISSUE goes to R_WAIT.
- R_WAIT: shadow<=rom_data, shadow_valid<=1, go to IDLE.
- Q_ISSUE goes to Q_WAIT.
- Q_WAIT: hit<=rom_data[latched col], go to Q_DONE.
- Q_DONE: q_ack=1 and q_hit=hit for exactly one cycle, go to IDLE.
- Query latency: q_req seen in IDLE at cycle t (no render pending) gives q_ack at t+3 (in range) or t+1 (out of range).
- Worst-case query latency is t+6, when a render fetch is granted first.
- Render fetch completes within 5 cycles of the trigger. It is always finished well before H_MAX, so the swap never sees a partial shadow.
- Query handshake rules:
  - Requester holds q_req until q_ack and drops it in the ack cycle or later.
  - If q_req is still high in the IDLE cycle after Q_DONE, it is treated as a new query.
  - Inputs are latched at accept; later changes are ignored until q_ack.
- Frame wrap: the line at v_counter==V_MAX fetches row 0.
- Lines with nrow>=MAP_H (v 420..599 at defaults) give row_valid=0 and row_bits=0.

Test Plan:
- Reset for 2 cycles with q_req=1 -> all outputs 0, no q_ack, rom_addr=0.
- ROM row5 = 30'h0000_0021. Drive v_counter=99, h_counter 640..799 -> rom_addr=5 in the cycle after the trigger. After h=799, row_bits=30'h21 and row_valid=1.
- Idle line; q_req with row=5, col=5 at cycle t -> q_ack pulses at t+3 with q_hit=1. Repeat with col=1 -> q_hit=0. Both with a single-cycle q_ack.
- q_req with row=21 or col=30 -> q_ack at t+1 with q_hit=1, and rom_addr never changes.
- q_req asserted in the same cycle h_counter==640 -> render fetch first; q_ack at t+6 with the correct value, and row_bits correct after the swap.
- v_counter=419 -> next line row 21 gives row_valid=0 and row_bits=0. v_counter=599 -> rom_addr=0 and row 0 is loaded. Assert reset during Q_WAIT -> no q_ack, FSM returns to IDLE.
